ifu_fetch: RTL

- Multi-cycle instruction fetch unit. It holds the architectural PC and issues one read per instruction on a valid/ready address/data bus to instruction memory.
- It presents the fetched 32-bit instruction and its PC to the decode stage, which feeds inst[31:7] to the immediate generator and opcode logic.
- After each delivered instruction it waits for the next-PC from the execute/writeback stage before fetching again.

---
 rtl/ifu_fetch.sv | 137 +++++++++++++
 1 files changed

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: holds the architectural PC, performs one
// valid/ready address/data read per instruction and hands the result to
// decode. It never advances the PC itself; every next PC arrives on npc.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | one-cycle pause after reset before the first request
// REQ      | arvalid high, araddr = pc, waiting for arready
// RESP     | rready high, waiting for rvalid
// DELIVER  | inst_valid high, result held until inst_ready
// WAIT_NPC | waiting for npc_valid; misaligned npc faults without a fetch
module ifu_fetch #(
    parameter int unsigned        XLEN     = 32,
    parameter logic [XLEN-1:0]    RESET_PC = 32'h8000_0000
) (
    input  logic            clk,
    input  logic            rst,
    output logic [XLEN-1:0] araddr,
    output logic            arvalid,
    input  logic            arready,
    input  logic [31:0]     rdata,
    input  logic [1:0]      rresp,
    input  logic            rvalid,
    output logic            rready,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] inst_pc,
    output logic            inst_fault,
    output logic            inst_valid,
    input  logic            inst_ready,
    input  logic [XLEN-1:0] npc,
    input  logic            npc_valid
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        REQ      = 3'd1,
        RESP     = 3'd2,
        DELIVER  = 3'd3,
        WAIT_NPC = 3'd4
    } state_t;

    state_t          state_q;
    logic [XLEN-1:0] pc_q;
    logic [31:0]     inst_q;
    logic [XLEN-1:0] inst_pc_q;
    logic            inst_fault_q;
    logic            arvalid_q;
    logic            rready_q;
    logic            inst_valid_q;

    logic [31:0]     inst_d;
    logic            inst_fault_d;
    logic            npc_aligned;

    // Response decode: an error response discards the returned word.
    always_comb begin
        inst_fault_d = (rresp != 2'b00);
        inst_d       = inst_fault_d ? 32'h0000_0000 : rdata;
        npc_aligned  = (npc[1:0] == 2'b00);
    end

    // Fetch sequencer; every bus and decode-side output is a register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            inst_q       <= 32'h0000_0000;
            inst_pc_q    <= '0;
            inst_fault_q <= 1'b0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            inst_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_q   <= REQ;
                    arvalid_q <= 1'b1;
                end
                REQ: begin
                    if (arready) begin
                        state_q   <= RESP;
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                    end
                end
                RESP: begin
                    if (rvalid) begin
                        state_q      <= DELIVER;
                        rready_q     <= 1'b0;
                        inst_q       <= inst_d;
                        inst_pc_q    <= pc_q;
                        inst_fault_q <= inst_fault_d;
                        inst_valid_q <= 1'b1;
                    end
                end
                DELIVER: begin
                    if (inst_ready) begin
                        state_q      <= WAIT_NPC;
                        inst_valid_q <= 1'b0;
                    end
                end
                WAIT_NPC: begin
                    if (npc_valid) begin
                        pc_q <= npc;
                        if (npc_aligned) begin
                            state_q   <= REQ;
                            arvalid_q <= 1'b1;
                        end else begin
                            // Misaligned target: report the fault directly,
                            // the bus is never touched.
                            state_q      <= DELIVER;
                            inst_q       <= 32'h0000_0000;
                            inst_pc_q    <= npc;
                            inst_fault_q <= 1'b1;
                            inst_valid_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    arvalid_q    <= 1'b0;
                    rready_q     <= 1'b0;
                    inst_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign araddr     = pc_q;
    assign arvalid    = arvalid_q;
    assign rready     = rready_q;
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;
    assign inst_fault = inst_fault_q;
    assign inst_valid = inst_valid_q;

endmodule
